// File: rtl/vram_pkg.sv
// Shared constants, grant/fill enums and the fixed-priority grant picker
// for the text-mode VRAM arbiter.
package vram_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CELLS  = 2400;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VID,
        GNT_CPU,
        GNT_FILL
    } gnt_e;

    typedef enum logic {
        FILL_IDLE,
        FILL_RUN
    } fill_state_e;

    // Video always wins; the CPU must already be filtered by its outstanding flag.
    function automatic gnt_e pick_grant(input logic vid, input logic cpu, input logic fill);
        if (vid) begin
            return GNT_VID;
        end
        if (cpu) begin
            return GNT_CPU;
        end
        if (fill) begin
            return GNT_FILL;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Request/response and VRAM-side signals of the arbiter, bundled with
// modports for the arbiter (slave) and its clients plus RAM (master).
interface vram_arbiter_if;
    import vram_pkg::*;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  fill_start, fill_value,
        input  ram_rdata,
        output vid_data, vid_valid,
        output cpu_ack, cpu_rdata,
        output fill_busy,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output fill_start, fill_value,
        output ram_rdata,
        input  vid_data, vid_valid,
        input  cpu_ack, cpu_rdata,
        input  fill_busy,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/vram_fill_seq.sv
// Screen-fill sequencer: walks every cell once, writing the latched value
// whenever the arbiter hands it a slot.
module vram_fill_seq
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              fill_gnt,
    output logic              fill_req,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_busy
);

    fill_state_e       state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] value;
    logic              busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                FILL_IDLE: begin
                    if (fill_start) begin
                        value <= fill_value;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= FILL_RUN;
                    end
                end
                FILL_RUN: begin
                    // fill_start is deliberately ignored here.
                    if (fill_gnt) begin
                        if (cnt == LAST_CELL) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= FILL_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= FILL_IDLE;
                end
            endcase
        end
    end

    assign fill_req  = busy;
    assign fill_busy = busy;
    assign fill_addr = cnt;
    assign fill_data = value;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scanout > CPU > screen fill, with a
// fixed two-cycle pipeline for video reads and CPU completions.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    vram_arbiter_if.slave bus
);

    gnt_e              gnt;
    logic              fill_req;
    logic              fill_gnt;
    logic              fill_busy;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;

    logic              cpu_out;
    logic              vid_vld_p0;
    logic              cpu_vld_p0;
    logic              cpu_rd_p0;
    logic              vid_vld_p1;
    logic              cpu_vld_p1;
    logic [DATA_W-1:0] vid_data_p1;
    logic [DATA_W-1:0] cpu_rdata_p1;

    vram_fill_seq u_fill (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_start (bus.fill_start),
        .fill_value (bus.fill_value),
        .fill_gnt   (fill_gnt),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy)
    );

    // No grant while in reset so a held cpu_req or stale fill cannot touch the RAM.
    always_comb begin
        gnt = GNT_NONE;
        if (rst_n) begin
            gnt = pick_grant(bus.vid_req, bus.cpu_req && !cpu_out, fill_req);
        end
    end

    assign fill_gnt = (gnt == GNT_FILL);

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        case (gnt)
            GNT_VID: begin
                bus.ram_addr = bus.vid_addr;
            end
            GNT_CPU: begin
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_we    = bus.cpu_we;
                bus.ram_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
            end
            GNT_FILL: begin
                bus.ram_addr  = fill_addr;
                bus.ram_we    = 1'b1;
                bus.ram_wdata = fill_data;
            end
            default: begin
                bus.ram_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vid_vld_p0   <= 1'b0;
            cpu_vld_p0   <= 1'b0;
            cpu_rd_p0    <= 1'b0;
            vid_vld_p1   <= 1'b0;
            cpu_vld_p1   <= 1'b0;
            vid_data_p1  <= '0;
            cpu_rdata_p1 <= '0;
            cpu_out      <= 1'b0;
        end else begin
            // Stage p0: remember what was granted while the RAM reads.
            vid_vld_p0 <= (gnt == GNT_VID);
            cpu_vld_p0 <= (gnt == GNT_CPU);
            cpu_rd_p0  <= (gnt == GNT_CPU) && !bus.cpu_we;

            // Stage p1: capture RAM data and raise the completion pulses.
            vid_vld_p1 <= vid_vld_p0;
            cpu_vld_p1 <= cpu_vld_p0;
            if (vid_vld_p0) begin
                vid_data_p1 <= bus.ram_rdata;
            end
            if (cpu_vld_p0 && cpu_rd_p0) begin
                cpu_rdata_p1 <= bus.ram_rdata;
            end

            // Outstanding spans the ack cycle, where cpu_req may still be high.
            if (gnt == GNT_CPU) begin
                cpu_out <= 1'b1;
            end else if (cpu_vld_p1) begin
                cpu_out <= 1'b0;
            end
        end
    end

    assign bus.vid_data  = vid_data_p1;
    assign bus.vid_valid = vid_vld_p1;
    assign bus.cpu_ack   = cpu_vld_p1;
    assign bus.cpu_rdata = cpu_rdata_p1;
    assign bus.fill_busy = fill_busy;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Single-port VRAM arbiter between three requesters: the character scanout fetch, the CPU port, and a built-in screen-fill sequencer.
- Sits between the 80x30 text-mode video timing block and the VRAM macro. It owns the RAM address, write-enable and write-data lines.
- Fixed priority per cycle: video > CPU > fill. Video always gets its slot; the CPU and fill use the remaining cycles.

Parameters:
- ADDR_W, 12, VRAM word address width (2400 cells fit).
- DATA_W, 16, cell width: [15:8] style, [7:0] character code.
- CELLS, 2400, number of cells the fill sequencer writes (80*30).

Ports:
- clk  in  1  pixel clock; every transition is on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- vid_req  in  1  one-cycle strobe: the scanout wants the cell at vid_addr.
- vid_addr  in  ADDR_W  scanout cell address; valid only while vid_req=1.
- vid_data  out  DATA_W  fetched cell, registered.
- vid_valid  out  1  one-cycle pulse: vid_data is updated.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1=write, 0=read; stable while cpu_req=1.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req=1.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read result, valid while cpu_ack=1 and held afterwards.
- fill_start  in  1  one-cycle strobe: write fill_value to all cells.
- fill_value  in  DATA_W  fill word, sampled on the accepted fill_start.
- fill_busy  out  1  fill sequencer is active.
- ram_addr  out  ADDR_W  VRAM address, combinational from the current grant.
- ram_we  out  1  VRAM write enable, combinational.
- ram_wdata  out  DATA_W  VRAM write data, combinational.
- ram_rdata  in  DATA_W  VRAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset values (rst_n=0 at a rising edge): vid_data=0, vid_valid=0, cpu_ack=0, cpu_rdata=0, fill_busy=0. ram_we=0 and ram_addr=0 while no grant is active.
- Reset mid-operation aborts everything:
  - any pending CPU access is dropped with no ack;
  - the fill stops, its counter clears, and the RAM keeps whatever was already written.
- Grant is evaluated combinationally every cycle G, with priority in this order:
  - vid_req=1: video grant (read).
  - Otherwise cpu_req=1 and no CPU access outstanding: CPU grant.
  - Otherwise fill_busy=1: fill write.
  - Otherwise idle, ram_we=0.
- Video read timing:
  - address is on ram_addr in cycle G;
  - ram_rdata is captured at G+1;
  - vid_data updates and vid_valid pulses in cycle G+2.
  - Fixed 2-cycle latency. Back-to-back vid_req is allowed; the path is fully pipelined.
- CPU timing:
  - On grant, an outstanding flag sets and blocks any regrant.
  - Write: ram_we=1 in G; cpu_ack pulses at G+2.
  - Read: cpu_rdata is loaded and cpu_ack pulses at G+2.
  - The outstanding flag clears with the ack.
  - cpu_req must be low in the cycle after the ack. A CPU request stalled by video keeps waiting with no timeout.
- Fill sequencer:
  - States: IDLE and RUN.
  - An accepted fill_start (in IDLE) latches fill_value, clears the counter and enters RUN. fill_busy=1 from the next cycle.
  - In RUN, each fill grant writes the counter address with the latched value, then increments the counter.
  - After the write to address CELLS-1, the block returns to IDLE and fill_busy=0 in the next cycle.
  - fill_start while in RUN is ignored.
- Concurrent CPU writes during a fill are allowed. Whichever write to a cell occurs last wins.
- Starvation: if vid_req is asserted every cycle, the CPU and fill are starved. The scanout duty (1 in 10 cycles) guarantees progress.
- Counter width is ADDR_W with no wrap. It never exceeds CELLS-1.

Decomposition:
- Shared package vram_pkg holds:
  - the ADDR_W, DATA_W and CELLS constants;
  - the grant enum {GNT_NONE, GNT_VID, GNT_CPU, GNT_FILL};
  - the fill state enum {FILL_IDLE, FILL_RUN}.
- One sub-module, vram_fill_seq, contains the fill FSM, counter and latched value. It exposes fill_req, fill_addr and fill_data, plus a grant input.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-traffic -> all outputs zero and no ack.
- Video latency: vid_req with vid_addr=5 where RAM[5]=16'h1F41 -> vid_valid pulses 2 cycles later with vid_data=16'h1F41. Back-to-back requests to 5 then 6 -> valid on two consecutive cycles.
- CPU collision: cpu_req write addr 100 data 16'hABCD, with vid_req in the same cycle -> video granted first; CPU write issued the next cycle; cpu_ack 2 cycles after that. A read of 100 then returns 16'hABCD.
- Fill: fill_start with value 16'h0720 under periodic vid_req every 10 cycles -> fill_busy deasserts after exactly 2400 fill writes. Sampled cells 0, 1234 and 2399 all read 16'h0720.
- Fill ignore and CPU during fill: second fill_start while busy -> no restart. A CPU write mid-fill is still acked. Reset during fill -> fill_busy=0 next cycle and remaining cells unchanged.
